// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the IMEM boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WR    = 3'd3,
        CHK   = 3'd4,
        FIN   = 3'd5,
        DONE  = 3'd6,
        ERROR = 3'd7
    } state_e;

    localparam int DEF_CWIDTH = 16;
    localparam int HDR_BYTES  = DEF_CWIDTH / 8;
    localparam int WORD_BYTES = 4;

    // Header length in bytes for a given count-field width.
    function automatic int hdr_bytes(input int cwidth);
        return cwidth / 8;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-lane shift register: four accepted bytes form one word.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
#(
    parameter int IWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic [IWIDTH-1:0] word,
    output logic              last_byte,
    output logic              word_valid
);

    logic [IWIDTH-1:0] word_q, word_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              valid_q, valid_d;

    always_comb begin
        word_d  = word_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (byte_en) begin
            // New byte enters the top lane so byte0 ends up in [7:0].
            word_d  = {byte_in, word_q[IWIDTH-1:8]};
            cnt_d   = cnt_q + 2'd1;
            valid_d = (cnt_q == 2'(WORD_BYTES - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign word       = word_q;
    assign last_byte  = (cnt_q == 2'(WORD_BYTES - 1));
    assign word_valid = valid_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time IMEM writer: header count + LE words over valid/ready, holds core in reset until loaded.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          IWIDTH    = 32,
    parameter int          AWIDTH    = 32,
    parameter int          CWIDTH    = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              ILoad,
    output logic [AWIDTH-1:0] IAddr,
    output logic [IWIDTH-1:0] instW,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CWIDTH-1:0] words_loaded
);

    localparam int                HDR_N  = hdr_bytes(CWIDTH);
    localparam logic [AWIDTH-1:0] BASE_A = AWIDTH'(BASE_ADDR);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e TAIL_ST = CHK;
`else
    localparam state_e TAIL_ST = FIN;
`endif

    state_e            state_q, state_d;
    logic [CWIDTH-1:0] count_q, count_d;
    logic [7:0]        hdr_cnt_q, hdr_cnt_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [CWIDTH-1:0] words_q, words_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hold_q, hold_d;
    logic              pk_clr, pk_en, pk_last, pk_valid;
    logic              accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
    logic              err_q, err_d;
`endif

    assign in_ready = (state_q == HDR) || (state_q == DATA) || (state_q == CHK);
    assign accept   = in_valid && in_ready;

    imem_loader_byte_packer #(.IWIDTH(IWIDTH)) u_packer (
        .clk        (clk),
        .rst_n      (rst),
        .clr        (pk_clr),
        .byte_en    (pk_en),
        .byte_in    (in_data),
        .word       (instW),
        .last_byte  (pk_last),
        .word_valid (pk_valid)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hdr_cnt_d = hdr_cnt_q;
        addr_d    = addr_q;
        words_d   = words_q;
        busy_d    = busy_q;
        done_d    = done_q;
        hold_d    = hold_q;
        pk_clr    = 1'b0;
        pk_en     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d   = HDR;
                    count_d   = '0;
                    hdr_cnt_d = '0;
                    addr_d    = BASE_A;
                    words_d   = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    hold_d    = 1'b1;
                    pk_clr    = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d    = '0;
                    err_d     = 1'b0;
`endif
                end
            end
            HDR: begin
                if (accept) begin
                    // Header arrives LSB first: shift each byte in from the top.
                    count_d = (CWIDTH'(in_data) << (CWIDTH - 8)) | (count_q >> 8);
                    if (hdr_cnt_q == 8'(HDR_N - 1)) begin
                        hdr_cnt_d = '0;
                        state_d   = (count_d == '0) ? TAIL_ST : DATA;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 8'd1;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    pk_en = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ in_data;
`endif
                    if (pk_last) begin
                        state_d = WR;
                    end
                end
            end
            WR: begin
                words_d = words_q + CWIDTH'(1);
                addr_d  = addr_q + AWIDTH'(WORD_BYTES);
                state_d = (words_d == count_q) ? TAIL_ST : DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d = FIN;
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
`endif
            FIN: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Flags take their final value on the edge entering FIN.
        if (state_d == FIN) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            hold_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            hdr_cnt_q <= '0;
            addr_q    <= BASE_A;
            words_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hold_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            hdr_cnt_q <= hdr_cnt_d;
            addr_q    <= addr_d;
            words_q   <= words_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hold_q    <= hold_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
            err_q  <= 1'b0;
        end else begin
            csum_q <= csum_d;
            err_q  <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign ILoad        = (state_q == WR) && pk_valid;
    assign IAddr        = addr_q;
    assign cpu_hold     = hold_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: byte-stream images checked against a queue-based model.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          HDR  = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, ILoad, cpu_hold, busy, done, err;
    logic [31:0] IAddr, instW;
    logic [15:0] words_loaded;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          mon_en = 1'b1;
    int          cur_n = 0;
    logic [7:0]  stream_q[$];
    wr_t         exp_q[$];
    int          exp_cyc_q[$];
    logic [31:0] img_q[$];
    wr_t         mon_e;
    int          mon_c;

    imem_loader dut (
        .clk          (clk),
        .rst          (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .ILoad        (ILoad),
        .IAddr        (IAddr),
        .instW        (instW),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every IMEM write must match the next expected word, address and cycle.
    always @(negedge clk) begin
        if (mon_en && rst_n && ILoad) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_iload", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = (exp_cyc_q.size() != 0) ? exp_cyc_q.pop_front() : -1;
                $display("write addr=%08h data=%08h cyc=%0d", IAddr, instW, cyc);
                check_eq("iaddr", IAddr, mon_e.addr);
                check_eq("instw", instW, mon_e.data);
                check_eq("wr_latency", cyc, mon_c);
                check_eq("ready_in_wr", in_ready, 0);
            end
        end
    end

    task automatic build(input int n, input logic [7:0] csum_xor);
        logic [7:0]  x;
        logic [31:0] w;
        x = 8'h00;
        stream_q.delete();
        exp_q.delete();
        exp_cyc_q.delete();
        cur_n = n;
        stream_q.push_back(8'(n));
        stream_q.push_back(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            w = img_q[i];
            for (int b = 0; b < 4; b++) begin
                stream_q.push_back(w[8*b +: 8]);
                x = x ^ w[8*b +: 8];
            end
            exp_q.push_back({BASE + 32'(4 * i), w});
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream_q.push_back(x ^ csum_xor);
`endif
        $display("load n=%0d csum=%02h", n, x ^ csum_xor);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_busy", busy, 1);
        check_eq("start_hold", cpu_hold, 1);
        check_eq("start_done", done, 0);
        check_eq("start_err", err, 0);
        check_eq("start_words", words_loaded, 0);
    endtask

    task automatic run_stream(input bit gaps, input int stop_at, input int start_at);
        int idx;
        int guard;
        bit pulsed;
        idx = 0;
        guard = 0;
        pulsed = 1'b0;
        while (idx < stream_q.size() && idx < stop_at && guard < 2000) begin
            @(negedge clk);
            if (idx == start_at && !pulsed) begin
                start = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data = stream_q[idx];
            if (in_valid && in_ready) begin
                if (idx >= HDR && idx < HDR + 4 * cur_n && ((idx - HDR) % 4) == 3)
                    exp_cyc_q.push_back(cyc + 1);
                idx++;
            end
            guard++;
        end
        if (guard >= 2000) check_eq("stream_timeout", 1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic finish_load(input bit exp_err);
        int w;
        w = 0;
        while (!(done || err) && w < 3) begin
            @(negedge clk);
            w++;
        end
        check_eq("load_complete", done || err, 1);
        check_eq("done", done, !exp_err);
        check_eq("err", err, exp_err);
        check_eq("cpu_hold", cpu_hold, exp_err);
        check_eq("busy_end", busy, 0);
        check_eq("words_loaded", words_loaded, cur_n);
        check_eq("writes_left", exp_q.size(), 0);
    endtask

    task automatic load(input bit gaps, input int start_at, input logic [7:0] csum_xor);
        bit exp_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_err = (csum_xor != 8'h00);
`else
        exp_err = 1'b0;
`endif
        do_start();
        run_stream(gaps, 1 << 30, start_at);
        finish_load(exp_err);
    endtask

    task automatic basic_image();
        img_q.delete();
        img_q.push_back(32'h0000_0013);
        img_q.push_back(32'h0010_0093);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_iload", ILoad, 0);
        check_eq("rst_iaddr", IAddr, BASE);
        check_eq("rst_instw", instW, 0);
        check_eq("rst_hold", cpu_hold, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_words", words_loaded, 0);

        // Basic two-word load, then zero-count image.
        basic_image();
        build(2, 8'h00);
        load(1'b0, -1, 8'h00);
        img_q.delete();
        build(0, 8'h00);
        load(1'b0, -1, 8'h00);

        // Same image with random in_valid gaps.
        basic_image();
        build(2, 8'h00);
        load(1'b1, -1, 8'h00);

`ifdef IMEM_LOADER_CHECKSUM_EN
        img_q.delete();
        img_q.push_back(32'h4433_2211);
        build(1, 8'h44);
        load(1'b0, -1, 8'h44);
`endif

        // start while busy: mid-DATA, and coincident with the last byte.
        basic_image();
        build(2, 8'h00);
        load(1'b1, HDR + 1, 8'h00);
        build(2, 8'h00);
        load(1'b0, stream_q.size() - 1, 8'h00);

        // Asynchronous reset while the first word is being written.
        basic_image();
        build(2, 8'h00);
        mon_en = 1'b0;
        do_start();
        run_stream(1'b0, 6, -1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_hold", cpu_hold, 1);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_iload", ILoad, 0);
        check_eq("mid_rst_ready", in_ready, 0);
        check_eq("mid_rst_iaddr", IAddr, BASE);
        check_eq("mid_rst_words", words_loaded, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        build(2, 8'h00);
        load(1'b0, -1, 8'h00);

        // Random images, gaps and occasionally corrupted checksums.
        for (int t = 0; t < 8; t++) begin
            int          n;
            logic [7:0]  cx;
            n = $urandom_range(0, 5);
            img_q.delete();
            for (int i = 0; i < n; i++) img_q.push_back($urandom());
            cx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            build(n, cx);
            load(1'b1, ($urandom_range(0, 1) != 0) ? HDR + 4 * n / 2 : -1, cx);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
